// File: rtl/slot_allocator.sv
// slot_allocator: N-slot ID allocator with occupancy tracking.
// Grants a free slot ID combinationally from the current occupancy vector,
// and releases slots by ID. Selection is lowest-free-first or round-robin.
module slot_allocator #(
    parameter int NUM_SLOTS = 4,
    parameter int RR_MODE   = 0,
    parameter int ID_W      = $clog2(NUM_SLOTS),
    parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    output logic                 alloc_gnt,
    output logic [ID_W-1:0]      alloc_id,
    input  logic                 dealloc,
    input  logic [ID_W-1:0]      dealloc_id,
    output logic                 dealloc_err,
    output logic [NUM_SLOTS-1:0] QValid,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty
);

    logic [ID_W-1:0]      ptr;
    logic                 sel_done;
    int                   scan_idx;
    logic [ID_W-1:0]      scan_id;
    logic [NUM_SLOTS-1:0] gnt_vec;
    logic [NUM_SLOTS-1:0] rel_vec;
    logic                 rel_ok;
    logic [CNT_W-1:0]     next_count;

    // Grant whenever a slot is free; reset masks the grant so nothing is reported while clearing.
    assign alloc_gnt = alloc & ~full & ~rst;

    // Pick the free slot: lowest index, or first free after the last grant (wrapping).
    always_comb begin
        alloc_id = '0;
        sel_done = 1'b0;
        scan_idx = 0;
        scan_id  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (RR_MODE != 0) begin
                scan_idx = int'(ptr) + 1 + k;
                if (scan_idx >= NUM_SLOTS) begin
                    scan_idx = scan_idx - NUM_SLOTS;
                end
            end else begin
                scan_idx = k;
            end
            scan_id = ID_W'(scan_idx);
            if (!sel_done && !QValid[scan_id]) begin
                alloc_id = scan_id;
                sel_done = 1'b1;
            end
        end
    end

    // Decode grant and release into per-slot vectors; out-of-range or free targets decode to nothing.
    always_comb begin
        gnt_vec = '0;
        rel_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            gnt_vec[i] = alloc_gnt && (alloc_id == ID_W'(i));
            rel_vec[i] = dealloc && (dealloc_id == ID_W'(i)) && QValid[i];
        end
        rel_ok     = |rel_vec;
        next_count = count + CNT_W'(alloc_gnt) - CNT_W'(rel_ok);
    end

    // Occupancy, count, flags, error pulse and round-robin pointer update together each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            QValid      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            dealloc_err <= 1'b0;
            ptr         <= ID_W'(NUM_SLOTS - 1);
        end else begin
            QValid      <= (QValid | gnt_vec) & ~rel_vec;
            count       <= next_count;
            full        <= (next_count == CNT_W'(NUM_SLOTS));
            empty       <= (next_count == '0);
            dealloc_err <= dealloc & ~rel_ok;
            if (alloc_gnt) begin
                ptr <= alloc_id;
            end
        end
    end

endmodule

// File: tb/tb_slot_allocator.sv
// Testbench for slot_allocator: one lowest-first and one round-robin instance
// (NUM_SLOTS=4), directed scenarios plus random traffic against a slot-set model.
module tb_slot_allocator;

    logic       clk;
    logic       rst;
    logic       i_alloc   [2];
    logic       i_dealloc [2];
    logic [1:0] i_did     [2];
    logic       o_gnt     [2];
    logic [1:0] o_id      [2];
    logic       o_err     [2];
    logic [3:0] o_qv      [2];
    logic [2:0] o_cnt     [2];
    logic       o_full    [2];
    logic       o_empty   [2];

    int checks   = 0;
    int failures = 0;

    // reference model: set of occupied slots, last granted slot, error flag
    bit [3:0] m_occ [2];
    int       m_ptr [2];
    bit       m_err [2];
    bit [3:0] n_occ [2];
    int       n_ptr [2];
    bit       n_err [2];
    bit       g_gnt [2];
    int       g_id  [2];

    slot_allocator #(.NUM_SLOTS(4), .RR_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .alloc(i_alloc[0]), .alloc_gnt(o_gnt[0]), .alloc_id(o_id[0]),
        .dealloc(i_dealloc[0]), .dealloc_id(i_did[0]), .dealloc_err(o_err[0]),
        .QValid(o_qv[0]), .count(o_cnt[0]), .full(o_full[0]), .empty(o_empty[0])
    );

    slot_allocator #(.NUM_SLOTS(4), .RR_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .alloc(i_alloc[1]), .alloc_gnt(o_gnt[1]), .alloc_id(o_id[1]),
        .dealloc(i_dealloc[1]), .dealloc_id(i_did[1]), .dealloc_err(o_err[1]),
        .QValid(o_qv[1]), .count(o_cnt[1]), .full(o_full[1]), .empty(o_empty[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // next slot by policy: lowest free, or first free after the last granted slot
    function automatic int pick(input bit [3:0] occ, input int rr, input int last);
        int slot;
        for (int k = 0; k < 4; k++) begin
            slot = rr ? (last + 1 + k) % 4 : k;
            if (!occ[slot]) return slot;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_occ[u] = 4'b0;
            m_ptr[u] = 3;
            m_err[u] = 1'b0;
        end
    endtask

    task automatic check_regs();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_qvalid", u), 32'(o_qv[u]), 32'(m_occ[u]));
            chk($sformatf("u%0d_count", u), 32'(o_cnt[u]), 32'($countones(m_occ[u])));
            chk($sformatf("u%0d_full", u), 32'(o_full[u]), 32'(m_occ[u] == 4'hF));
            chk($sformatf("u%0d_empty", u), 32'(o_empty[u]), 32'(m_occ[u] == 4'h0));
            chk($sformatf("u%0d_err", u), 32'(o_err[u]), 32'(m_err[u]));
            chk($sformatf("u%0d_inv_popcount", u), 32'(o_cnt[u]), 32'($countones(o_qv[u])));
            chk($sformatf("u%0d_inv_full_empty", u), 32'(o_full[u] & o_empty[u]), 32'd0);
        end
    endtask

    // one clock: drive at negedge, check combinational grant, then registered state after the edge
    task automatic cyc(input bit a0, input bit d0, input int id0,
                       input bit a1, input bit d1, input int id1);
        bit exp_gnt;
        bit rel;
        int sel;
        @(negedge clk);
        i_alloc[0] = a0; i_dealloc[0] = d0; i_did[0] = 2'(id0);
        i_alloc[1] = a1; i_dealloc[1] = d1; i_did[1] = 2'(id1);
        #1;
        for (int u = 0; u < 2; u++) begin
            exp_gnt = i_alloc[u] && (m_occ[u] != 4'hF);
            sel = pick(m_occ[u], u, m_ptr[u]);
            chk($sformatf("u%0d_gnt", u), 32'(o_gnt[u]), 32'(exp_gnt));
            if (exp_gnt) chk($sformatf("u%0d_id", u), 32'(o_id[u]), 32'(sel));
            chk($sformatf("u%0d_inv_gnt_free", u), 32'(o_gnt[u] & o_qv[u][o_id[u]]), 32'd0);
            g_gnt[u] = o_gnt[u];
            g_id[u]  = int'(o_id[u]);
            n_occ[u] = m_occ[u];
            n_ptr[u] = m_ptr[u];
            if (exp_gnt) begin
                n_occ[u][sel] = 1'b1;
                n_ptr[u] = sel;
            end
            rel = i_dealloc[u] && m_occ[u][i_did[u]];
            if (rel) n_occ[u][i_did[u]] = 1'b0;
            n_err[u] = i_dealloc[u] && !rel;
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            m_occ[u] = n_occ[u];
            m_ptr[u] = n_ptr[u];
            m_err[u] = n_err[u];
        end
        check_regs();
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            i_alloc[u] = 1'b0; i_dealloc[u] = 1'b0; i_did[u] = 2'd0;
        end
        model_reset();
        #12;
        chk("rst_qvalid", 32'(o_qv[0]), 32'd0);
        chk("rst_count", 32'(o_cnt[0]), 32'd0);
        chk("rst_full", 32'(o_full[0]), 32'd0);
        chk("rst_empty", 32'(o_empty[0]), 32'd1);
        chk("rst_err", 32'(o_err[0]), 32'd0);
        check_regs();
        @(negedge clk);
        rst = 1'b0;

        // fill lowest-first: ids 0..3, then blocked
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("fill_gnt", 32'(g_gnt[0]), 32'd1);
            chk("fill_id", 32'(g_id[0]), 32'(i));
            chk("fill_qv", 32'(o_qv[0]), 32'((1 << (i + 1)) - 1));
        end
        chk("fill_full", 32'(o_full[0]), 32'd1);
        chk("fill_count", 32'(o_cnt[0]), 32'd4);
        cyc(1, 0, 0, 0, 0, 0);
        chk("full_blocked_gnt", 32'(g_gnt[0]), 32'd0);

        // full with simultaneous alloc and release of slot 2
        cyc(1, 1, 2, 0, 0, 0);
        chk("full_coll_gnt", 32'(g_gnt[0]), 32'd0);
        chk("full_coll_qv", 32'(o_qv[0]), 32'b1011);
        cyc(1, 0, 0, 0, 0, 0);
        chk("refill_id", 32'(g_id[0]), 32'd2);
        chk("refill_qv", 32'(o_qv[0]), 32'b1111);

        // drain 0..3
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, i, 0, 0, 0);
            chk("drain_qv", 32'(o_qv[0]), 32'(4'(4'hF << (i + 1))));
            chk("drain_err", 32'(o_err[0]), 32'd0);
        end
        chk("drain_empty", 32'(o_empty[0]), 32'd1);

        // 0011 then alloc + release slot 1 together
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("swap_id", 32'(g_id[0]), 32'd2);
        chk("swap_qv", 32'(o_qv[0]), 32'b0101);
        chk("swap_count", 32'(o_cnt[0]), 32'd2);

        // release a free slot -> one-cycle error pulse
        cyc(0, 1, 2, 0, 0, 0);
        chk("pre_err_qv", 32'(o_qv[0]), 32'b0001);
        cyc(0, 1, 3, 0, 0, 0);
        chk("bad_rel_qv", 32'(o_qv[0]), 32'b0001);
        chk("bad_rel_err", 32'(o_err[0]), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("bad_rel_err_clear", 32'(o_err[0]), 32'd0);

        // round-robin: 0,1, free 0, then 2,3,0
        cyc(0, 0, 0, 1, 0, 0);
        chk("rr_id0", 32'(g_id[1]), 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rr_id1", 32'(g_id[1]), 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rr_id2", 32'(g_id[1]), 32'd2);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rr_id3", 32'(g_id[1]), 32'd3);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rr_wrap_id", 32'(g_id[1]), 32'd0);
        chk("rr_wrap_qv", 32'(o_qv[1]), 32'b1111);

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // reset asserted mid-stream with alloc held
        @(negedge clk);
        i_alloc[0] = 1'b1; i_alloc[1] = 1'b1;
        i_dealloc[0] = 1'b0; i_dealloc[1] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_midrst_qv", u), 32'(o_qv[u]), 32'd0);
            chk($sformatf("u%0d_midrst_gnt", u), 32'(o_gnt[u]), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_midrst_gnt_hold", u), 32'(o_gnt[u]), 32'd0);
            chk($sformatf("u%0d_midrst_cnt", u), 32'(o_cnt[u]), 32'd0);
        end
        model_reset();
        check_regs();
        @(negedge clk);
        rst = 1'b0;
        i_alloc[0] = 1'b0; i_alloc[1] = 1'b0;

        for (int n = 0; n < 60; n++) begin
            cyc(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
